fullmatch_mem_mc: RTL and testbench
===================================

# fullmatch_mem_mc

Multi-channel, BX-paged full-match memory: the parametrised successor of the single-channel full-match buffer. It captures match words from N_CH independent match-calculator channels into per-channel banks, paged by bunch crossing. It keeps a per-(channel, page) entry count with saturation and a sticky overflow flag. It sits between the match calculators and the track-fit stage, which reads any channel and page by address.

## Interface
- DATA_W, 40: match word width.
- N_CH, 2: number of input channels; each gets its own bank.
- ENTRY_W, 5: entry address width per page; 2^ENTRY_W entries per page.
- PAGE_W, 4: BX page address width; 2^PAGE_W pages, circular.
- TMUX, `tmux: start-to-done delay in cycles.
- CH_W, max(1, clog2(N_CH)): derived, read channel select width.
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 2: bit0 = new BX (page advance); bit1 = pipelined synchronous flush.
- done, out, 2: start delayed TMUX cycles.
- data_in, in, N_CH*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
- enable, in, N_CH: per-channel write valid.
- read_ch, in, CH_W: channel select for read.
- read_page, in, PAGE_W: page select for read.
- read_add, in, ENTRY_W: entry select for read.
- read_en, in, 1: data read enable and output-register enable.
- data_out, out, DATA_W: memory read data.
- number_out, out, ENTRY_W+1: entry count of (read_ch, read_page), 0..2^ENTRY_W.
- overflow_out, out, 1: sticky overflow of (read_ch, read_page).

## Operation
- reset low, asynchronously applied:
  - wr_page = all ones; all counters and count/overflow tables = 0.
  - data_out, number_out, overflow_out, done, and pipeline valids = 0.
  - Memory contents are not cleared.
- start[1] (flush) is a synchronous equivalent of reset and takes priority over start[0] in the same cycle. Memory contents are kept. done still pipes start normally.
- start[0] in cycle t: wr_page increments, wrapping from all ones to 0. Inputs sampled in cycle t and later belong to the new page.
- Write pipeline is 2 stages. data_in, enable, the page tag and a new_page flag (start[0]) all travel together.
- Stage 2, per channel:
  - If new_page: counter restarts at 0, and the count/overflow entries for (c, tag) are cleared before any write that cycle.
  - If valid and cnt < 2^ENTRY_W: write to bank c at {tag, cnt[ENTRY_W-1:0]}, cnt++, count entry = cnt+1.
  - If valid and cnt == 2^ENTRY_W: word dropped, overflow entry for (c, tag) set, count saturates.
- Channels write independently in the same cycle; there is no arbitration.
- Data read: address {read_ch, read_page, read_add}.
  - Two output register stages, both gated by read_en; data_out holds while read_en is low.
  - Read-during-write at the same address returns the old word.
- Count read: one register stage, not gated. A same-cycle update returns the pre-update value.
- A page not written since reset or flush reads count 0, overflow 0.
- Page wrap overwrites the oldest page. Consumers must finish reading within 2^PAGE_W - 1 BX.

## Timing
- done(t+TMUX) = start(t).
- Input sampled at edge t → stored at edge t+2 → visible to read_add presented at t+3 → data_out valid at t+5.
- number_out reflects the write stored at edge t+2 when read_page is presented at t+3, with the result registered at t+4.
- number_out and overflow_out latency: 1 cycle. data_out latency: 2 cycles with read_en high for both cycles.
- Flush at edge t: counters and tables read 0 from t+1. Words already in the pipeline are discarded.

## Structure
- Shared constants header: `tmux, default DATA_W/ENTRY_W/PAGE_W.
- One sub-module, fullmatch_bank, instantiated N_CH times via generate. It contains:
  - a simple dual-port RAM of DATA_W x 2^(PAGE_W+ENTRY_W);
  - the channel's write counter;
  - the count/overflow register arrays.
- The top level holds wr_page, the start/done delay, the input pipeline, and the read-channel output mux.
- The read-channel mux sits after each bank's first read register.

## Test plan
- Reset mid-stream: 3 writes on ch0, then reset low for 1 cycle → number_out 0, data_out 0, done 0. The next start[0] uses page 0.
- Single page, two channels: start[0], then ch0 writes 0xA0..0xA2 and ch1 writes 0xB0 in the same cycles → (ch0, p0) count 3 and reads A0, A1, A2; (ch1, p0) count 1 and reads B0.
- Overflow, ENTRY_W=5: 34 valid words on ch1 → count 32, overflow 1, entry 31 = word 31. ch0 overflow stays 0.
- Page wrap, PAGE_W=4: 17 start[0] pulses, 1 write per page → page 0 is rewritten, count 1 with the new data.
- Boundary coincidence: start[0] and enable in the same cycle → the word lands at address 0 of the new page, not the old.
- Flush priority: start = 2'b11 with 2 words in flight → all counts 0, the in-flight words are dropped, and done = 2'b11 after TMUX cycles.

Source files
------------

// File: rtl/fullmatch_mem_mc_pkg.sv
// Shared constants for the multi-channel full-match memory: default geometry,
// start-word bit positions and the read-channel select width helper.
package fullmatch_mem_mc_pkg;

  localparam int TMUX_DEF    = 4;
  localparam int DATA_W_DEF  = 40;
  localparam int ENTRY_W_DEF = 5;
  localparam int PAGE_W_DEF  = 4;

  localparam int START_BX    = 0;
  localparam int START_FLUSH = 1;

  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/fullmatch_bank.sv
// One channel's BX-paged bank: match-word RAM, write counter and the per-page
// entry-count / sticky-overflow tables.
module fullmatch_bank #(
  parameter int DATA_W  = 40,
  parameter int ENTRY_W = 5,
  parameter int PAGE_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_flush,
  input  logic                      i_new_page,
  input  logic                      i_vld,
  input  logic [PAGE_W-1:0]         i_tag,
  input  logic [DATA_W-1:0]         i_data,
  input  logic                      i_rd_en,
  input  logic [PAGE_W+ENTRY_W-1:0] i_rd_addr,
  input  logic [PAGE_W-1:0]         i_cnt_page,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic [ENTRY_W:0]          o_count,
  output logic                      o_ovf
);

  localparam int PAGES = 1 << PAGE_W;
  localparam int DEPTH = 1 << (PAGE_W + ENTRY_W);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0]  r_rd_p1;
  logic [ENTRY_W:0]   r_cnt;
  logic [ENTRY_W:0]   r_count [PAGES];
  logic [PAGES-1:0]   r_ovf;
  logic [ENTRY_W:0]   w_base;
  logic               w_wr;

  // A new page restarts the counter before this cycle's word is placed.
  assign w_base = i_new_page ? '0 : r_cnt;
  assign w_wr   = i_vld && !i_flush && !w_base[ENTRY_W];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[{i_tag, w_base[ENTRY_W-1:0]}] <= i_data;
    if (i_rd_en) r_rd_p1 <= r_mem[i_rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_ovf <= '0;
      for (int p = 0; p < PAGES; p++) r_count[p] <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
      r_ovf <= '0;
      for (int p = 0; p < PAGES; p++) r_count[p] <= '0;
    end else begin
      if (i_new_page) begin
        r_count[i_tag] <= '0;
        r_ovf[i_tag]   <= 1'b0;
      end
      if (w_wr) begin
        r_cnt          <= w_base + 1'b1;
        r_count[i_tag] <= w_base + 1'b1;
      end else begin
        r_cnt <= w_base;
        if (i_vld) r_ovf[i_tag] <= 1'b1;
      end
    end
  end

  assign o_rd_data = r_rd_p1;
  assign o_count   = r_count[i_cnt_page];
  assign o_ovf     = r_ovf[i_cnt_page];

endmodule

// File: rtl/fullmatch_mem_mc.sv
// Multi-channel full-match memory: page tracking, done delay, two-stage write
// pipeline shared by all channel banks, and the read-channel output mux.
module fullmatch_mem_mc
  import fullmatch_mem_mc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_CH    = 2,
  parameter int ENTRY_W = ENTRY_W_DEF,
  parameter int PAGE_W  = PAGE_W_DEF,
  parameter int TMUX    = TMUX_DEF,
  parameter int CH_W    = ch_width(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             start,
  output logic [1:0]             done,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [N_CH-1:0]        enable,
  input  logic [CH_W-1:0]        read_ch,
  input  logic [PAGE_W-1:0]      read_page,
  input  logic [ENTRY_W-1:0]     read_add,
  input  logic                   read_en,
  output logic [DATA_W-1:0]      data_out,
  output logic [ENTRY_W:0]       number_out,
  output logic                   overflow_out
);

  logic [PAGE_W-1:0]      r_wr_page;
  logic [1:0]             r_done_pipe [TMUX];
  logic [N_CH*DATA_W-1:0] r_data_p1, r_data_p2;
  logic [N_CH-1:0]        r_vld_p1, r_vld_p2;
  logic [PAGE_W-1:0]      r_tag_p1, r_tag_p2;
  logic                   r_new_p1, r_new_p2;
  logic [CH_W-1:0]        r_rd_ch_p1;
  logic [PAGE_W-1:0]      w_page_next;
  logic [DATA_W-1:0]      w_rd_data [N_CH];
  logic [ENTRY_W:0]       w_count [N_CH];
  logic [N_CH-1:0]        w_ovf;
  logic [DATA_W-1:0]      w_sel_data;
  logic [ENTRY_W:0]       w_sel_cnt;
  logic                   w_sel_ovf;

  assign w_page_next = r_wr_page + 1'b1;

  // Flush behaves like reset for paging and discards everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_page <= '1;
      r_vld_p1  <= '0;
      r_vld_p2  <= '0;
      r_new_p1  <= 1'b0;
      r_new_p2  <= 1'b0;
      r_tag_p1  <= '0;
      r_tag_p2  <= '0;
    end else if (start[START_FLUSH]) begin
      r_wr_page <= '1;
      r_vld_p1  <= '0;
      r_vld_p2  <= '0;
      r_new_p1  <= 1'b0;
      r_new_p2  <= 1'b0;
    end else begin
      if (start[START_BX]) r_wr_page <= w_page_next;
      r_vld_p1 <= enable;
      r_new_p1 <= start[START_BX];
      r_tag_p1 <= start[START_BX] ? w_page_next : r_wr_page;
      r_vld_p2 <= r_vld_p1;
      r_new_p2 <= r_new_p1;
      r_tag_p2 <= r_tag_p1;
    end
  end

  always_ff @(posedge clk) begin
    r_data_p1 <= data_in;
    r_data_p2 <= r_data_p1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TMUX; i++) r_done_pipe[i] <= '0;
    end else begin
      r_done_pipe[0] <= start;
      for (int i = 1; i < TMUX; i++) r_done_pipe[i] <= r_done_pipe[i-1];
    end
  end

  assign done = r_done_pipe[TMUX-1];

  for (genvar c = 0; c < N_CH; c++) begin : g_bank
    fullmatch_bank #(
      .DATA_W (DATA_W),
      .ENTRY_W(ENTRY_W),
      .PAGE_W (PAGE_W)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .i_flush   (start[START_FLUSH]),
      .i_new_page(r_new_p2),
      .i_vld     (r_vld_p2[c]),
      .i_tag     (r_tag_p2),
      .i_data    (r_data_p2[c*DATA_W +: DATA_W]),
      .i_rd_en   (read_en),
      .i_rd_addr ({read_page, read_add}),
      .i_cnt_page(read_page),
      .o_rd_data (w_rd_data[c]),
      .o_count   (w_count[c]),
      .o_ovf     (w_ovf[c])
    );
  end

  // Data selects on the channel registered alongside the bank read stage.
  always_comb begin
    w_sel_data = '0;
    w_sel_cnt  = '0;
    w_sel_ovf  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (CH_W'(c) == r_rd_ch_p1) w_sel_data = w_rd_data[c];
      if (CH_W'(c) == read_ch) begin
        w_sel_cnt = w_count[c];
        w_sel_ovf = w_ovf[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ch_p1   <= '0;
      data_out     <= '0;
      number_out   <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (read_en) begin
        r_rd_ch_p1 <= read_ch;
        data_out   <= w_sel_data;
      end
      number_out   <= w_sel_cnt;
      overflow_out <= w_sel_ovf;
    end
  end

endmodule

// File: tb/tb_fullmatch_mem_mc.sv
// Directed bench for fullmatch_mem_mc: reset, paging, overflow, wrap, flush.
module tb_fullmatch_mem_mc;
  import fullmatch_mem_mc_pkg::*;

  localparam int DATA_W  = 40;
  localparam int N_CH    = 2;
  localparam int ENTRY_W = 5;
  localparam int PAGE_W  = 4;
  localparam int TMUX    = TMUX_DEF;

  logic                   clk;
  logic                   reset;
  logic [1:0]             start;
  logic [1:0]             done;
  logic [N_CH*DATA_W-1:0] data_in;
  logic [N_CH-1:0]        enable;
  logic [0:0]             read_ch;
  logic [PAGE_W-1:0]      read_page;
  logic [ENTRY_W-1:0]     read_add;
  logic                   read_en;
  logic [DATA_W-1:0]      data_out;
  logic [ENTRY_W:0]       number_out;
  logic                   overflow_out;

  int n_vec = 0;
  int n_err = 0;

  fullmatch_mem_mc #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH),
    .ENTRY_W(ENTRY_W),
    .PAGE_W (PAGE_W),
    .TMUX   (TMUX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .data_in     (data_in),
    .enable      (enable),
    .read_ch     (read_ch),
    .read_page   (read_page),
    .read_add    (read_add),
    .read_en     (read_en),
    .data_out    (data_out),
    .number_out  (number_out),
    .overflow_out(overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] st, input logic [1:0] en,
                       input logic [39:0] d0, input logic [39:0] d1);
    start   = st;
    enable  = en;
    data_in = {d1, d0};
    tick();
    start  = 2'b00;
    enable = 2'b00;
  endtask

  task automatic chk_word(input string tag, input logic ch, input logic [3:0] pg,
                          input logic [4:0] ad, input logic [39:0] exp);
    read_ch   = ch;
    read_page = pg;
    read_add  = ad;
    read_en   = 1'b1;
    tick();
    tick();
    read_en = 1'b0;
    check(tag, 64'(data_out), 64'(exp));
  endtask

  task automatic chk_cnt(input string tag, input logic ch, input logic [3:0] pg,
                         input logic [5:0] exp_n, input logic exp_o);
    read_ch   = ch;
    read_page = pg;
    tick();
    check({tag, "_num"}, 64'(number_out), 64'(exp_n));
    check({tag, "_ovf"}, 64'(overflow_out), 64'(exp_o));
  endtask

  initial begin
    reset = 1'b0; start = '0; enable = '0; data_in = '0;
    read_ch = '0; read_page = '0; read_add = '0; read_en = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("init_number", 64'(number_out), 64'd0);
    check("init_data", 64'(data_out), 64'd0);
    check("init_done", 64'(done), 64'd0);
    check("init_ovf", 64'(overflow_out), 64'd0);

    // reset in the middle of a page
    drive(2'b01, 2'b00, 40'h0, 40'h0);
    drive(2'b00, 2'b01, 40'hF0, 40'h0);
    drive(2'b00, 2'b01, 40'hF1, 40'h0);
    drive(2'b00, 2'b01, 40'hF2, 40'h0);
    repeat (3) tick();
    chk_word("prerst_word", 1'b0, 4'd0, 5'd0, 40'hF0);
    chk_cnt("prerst_cnt", 1'b0, 4'd0, 6'd3, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_number", 64'(number_out), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    tick();
    reset = 1'b1;
    chk_cnt("rst_clr", 1'b0, 4'd0, 6'd0, 1'b0);

    // single page, two channels; first page after reset is page 0
    drive(2'b01, 2'b00, 40'h0, 40'h0);
    drive(2'b00, 2'b11, 40'hA0, 40'hB0);
    drive(2'b00, 2'b01, 40'hA1, 40'h0);
    drive(2'b00, 2'b01, 40'hA2, 40'h0);
    repeat (3) tick();
    chk_cnt("ch0p0", 1'b0, 4'd0, 6'd3, 1'b0);
    chk_word("ch0p0_w0", 1'b0, 4'd0, 5'd0, 40'hA0);
    chk_word("ch0p0_w1", 1'b0, 4'd0, 5'd1, 40'hA1);
    chk_word("ch0p0_w2", 1'b0, 4'd0, 5'd2, 40'hA2);
    chk_cnt("ch1p0", 1'b1, 4'd0, 6'd1, 1'b0);
    chk_word("ch1p0_w0", 1'b1, 4'd0, 5'd0, 40'hB0);
    read_ch = 1'b0; read_add = 5'd1;
    repeat (2) tick();
    check("hold_data", 64'(data_out), 64'hB0);

    // overflow on ch1, page 1
    drive(2'b01, 2'b00, 40'h0, 40'h0);
    for (int i = 0; i < 34; i++) drive(2'b00, 2'b10, 40'h0, 40'h1000 + 40'(i));
    repeat (3) tick();
    chk_cnt("ovf_ch1", 1'b1, 4'd1, 6'd32, 1'b1);
    chk_word("ovf_last", 1'b1, 4'd1, 5'd31, 40'h101F);
    chk_word("ovf_first", 1'b1, 4'd1, 5'd0, 40'h1000);
    chk_cnt("ovf_ch0", 1'b0, 4'd1, 6'd0, 1'b0);

    // start[0] and enable together: word goes to the new page
    drive(2'b01, 2'b01, 40'hC0, 40'h0);
    repeat (3) tick();
    chk_cnt("coin_new", 1'b0, 4'd2, 6'd1, 1'b0);
    chk_word("coin_word", 1'b0, 4'd2, 5'd0, 40'hC0);
    chk_cnt("coin_old", 1'b0, 4'd1, 6'd0, 1'b0);
    chk_cnt("coin_ch1", 1'b1, 4'd2, 6'd0, 1'b0);
    chk_cnt("coin_keep", 1'b1, 4'd1, 6'd32, 1'b1);

    // flush with two words in flight, together with start[0]
    drive(2'b00, 2'b01, 40'hC1, 40'h0);
    drive(2'b00, 2'b01, 40'hC2, 40'h0);
    drive(2'b11, 2'b00, 40'h0, 40'h0);
    repeat (TMUX - 2) tick();
    check("flush_done_early", 64'(done), 64'd0);
    tick();
    check("flush_done", 64'(done), 64'd3);
    repeat (3) tick();
    chk_cnt("flush_ch0p2", 1'b0, 4'd2, 6'd0, 1'b0);
    chk_cnt("flush_ch1p1", 1'b1, 4'd1, 6'd0, 1'b0);
    chk_cnt("flush_ch0p0", 1'b0, 4'd0, 6'd0, 1'b0);
    chk_word("flush_mem_kept", 1'b0, 4'd2, 5'd0, 40'hC0);

    // 17 page advances after flush: pages 0..15 then 0 again
    for (int k = 0; k < 17; k++) drive(2'b01, 2'b01, 40'hE00 + 40'(k), 40'h0);
    repeat (3) tick();
    chk_cnt("wrap_p0", 1'b0, 4'd0, 6'd1, 1'b0);
    chk_word("wrap_p0_word", 1'b0, 4'd0, 5'd0, 40'hE10);
    chk_cnt("wrap_p5", 1'b0, 4'd5, 6'd1, 1'b0);
    chk_word("wrap_p5_word", 1'b0, 4'd5, 5'd0, 40'hE05);
    chk_word("wrap_p15_word", 1'b0, 4'd15, 5'd0, 40'hE0F);
    chk_cnt("wrap_ch1", 1'b1, 4'd0, 6'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
